// File: rtl/ovf_pkg.sv
// Shared definitions for the overflow-guarded accumulator: FSM state
// encodings and constant functions that build the saturation limits for any
// operand width up to SAT_W bits.
package ovf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int SAT_W = 64;

  // Largest unsigned value of an n-bit word: all ones.
  function automatic logic [SAT_W-1:0] sat_max_u(input int n);
    logic [SAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i < n) r[i] = 1'b1;
      else       r[i] = 1'b0;
    end
    return r;
  endfunction

  // Most positive two's-complement value of an n-bit word: 0111...1.
  function automatic logic [SAT_W-1:0] sat_max_s(input int n);
    logic [SAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i < n - 1) r[i] = 1'b1;
      else           r[i] = 1'b0;
    end
    return r;
  endfunction

  // Most negative two's-complement value of an n-bit word: 1000...0.
  function automatic logic [SAT_W-1:0] sat_min_s(input int n);
    logic [SAT_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i == n - 1) r[i] = 1'b1;
      else            r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ovf_add_check.sv
// Combinational N-bit adder with overflow detection. The unsigned rule flags
// a carry out of the top bit; the signed rule flags two same-sign operands
// whose sum has the opposite sign.
module ovf_add_check #(
  parameter int N = 8
) (
  input  logic [N-1:0] acc,
  input  logic [N-1:0] operand,
  input  logic         is_signed,
  output logic [N-1:0] raw,
  output logic         ovf
);

  logic [N:0] full_sum_s;

  // Add with one extra bit to capture the carry, then pick the overflow rule.
  always_comb begin
    full_sum_s = {1'b0, acc} + {1'b0, operand};
    raw        = full_sum_s[N-1:0];
    if (is_signed) begin
      ovf = (acc[N-1] == operand[N-1]) && (full_sum_s[N-1] != acc[N-1]);
    end else begin
      ovf = full_sum_s[N];
    end
  end

endmodule

// File: rtl/ovf_sat_accumulator.sv
// Burst accumulator: takes a counted burst of operands over valid/ready,
// sums them with per-burst signed/unsigned overflow detection and optional
// saturation, then holds the result on a valid/ready output.
module ovf_sat_accumulator
  import ovf_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int OVC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             is_signed,
  input  logic             sat_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             ovf_sticky,
  output logic [OVC_W-1:0] ovf_count,
  output logic             busy
);

  localparam logic [N-1:0]     SAT_MAX_U = N'(sat_max_u(N));
  localparam logic [N-1:0]     SAT_MAX_S = N'(sat_max_s(N));
  localparam logic [N-1:0]     SAT_MIN_S = N'(sat_min_s(N));
  localparam logic [OVC_W-1:0] OVC_MAX   = {OVC_W{1'b1}};

  state_e           state_r, state_s;
  logic [N-1:0]     acc_r, acc_s;
  logic [CNT_W-1:0] remaining_r, remaining_s;
  logic             is_signed_r, is_signed_s;
  logic             sat_en_r, sat_en_s;
  logic             sticky_r, sticky_s;
  logic [OVC_W-1:0] count_r, count_s;
  logic             in_ready_r, out_valid_r, busy_r;
  logic [N-1:0]     raw_s;
  logic             ovf_s;
  logic             accept_s;

  ovf_add_check #(.N(N)) u_add_check (
    .acc       (acc_r),
    .operand   (in_data),
    .is_signed (is_signed_r),
    .raw       (raw_s),
    .ovf       (ovf_s)
  );

  assign accept_s = in_valid & in_ready_r;

  // Next-state and datapath update: sequencing, saturation mux, counters.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    remaining_s = remaining_r;
    is_signed_s = is_signed_r;
    sat_en_s    = sat_en_r;
    sticky_s    = sticky_r;
    count_s     = count_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          is_signed_s = is_signed;
          sat_en_s    = sat_en;
          acc_s       = '0;
          sticky_s    = 1'b0;
          count_s     = '0;
          remaining_s = len;
          if (len == '0) state_s = ST_HOLD;
          else           state_s = ST_ACC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (accept_s) begin
          if (ovf_s && sat_en_r) begin
            if (!is_signed_r)   acc_s = SAT_MAX_U;
            else if (acc_r[N-1]) acc_s = SAT_MIN_S;
            else                 acc_s = SAT_MAX_S;
          end else begin
            acc_s = raw_s;
          end
          if (ovf_s) begin
            sticky_s = 1'b1;
            if (count_r != OVC_MAX) count_s = count_r + OVC_W'(1'b1);
            else                    count_s = count_r;
          end else begin
            sticky_s = sticky_r;
          end
          remaining_s = remaining_r - CNT_W'(1'b1);
          if (remaining_r == CNT_W'(1'b1)) state_s = ST_HOLD;
          else                             state_s = ST_ACC;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_HOLD;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and Moore-decoded output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      remaining_r <= '0;
      is_signed_r <= 1'b0;
      sat_en_r    <= 1'b0;
      sticky_r    <= 1'b0;
      count_r     <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      remaining_r <= remaining_s;
      is_signed_r <= is_signed_s;
      sat_en_r    <= sat_en_s;
      sticky_r    <= sticky_s;
      count_r     <= count_s;
      in_ready_r  <= (state_s == ST_ACC);
      out_valid_r <= (state_s == ST_HOLD);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign out_sum    = acc_r;
  assign ovf_sticky = sticky_r;
  assign ovf_count  = count_r;

endmodule

// File: tb/tb_ovf_sat_accumulator.sv
// Directed self-checking bench for ovf_sat_accumulator with hand-computed
// expected values and immediate assertions at every check point.
module tb_ovf_sat_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       is_signed;
  logic       sat_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       ovf_sticky;
  logic [3:0] ovf_count;
  logic       busy;

  int n_assert;
  int n_fail;

  ovf_sat_accumulator #(.N(8), .CNT_W(8), .OVC_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .is_signed  (is_signed),
    .sat_en     (sat_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count),
    .busy       (busy)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l, input logic s, input logic sat);
    start = 1'b1; len = l; is_signed = s; sat_en = sat;
    tick();
    start = 1'b0; len = 8'd0; is_signed = 1'b0; sat_en = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d, input int gap);
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0; in_data = 8'd0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] sum,
                              input logic stk, input logic [3:0] cnt);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_sticky"}, ovf_sticky, stk);
    check({tag, "_count"}, ovf_count, cnt);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_valid"}, out_valid, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; len = 8'd0; is_signed = 1'b0; sat_en = 1'b0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", out_sum, 8'd0);
    check("rst_sticky", ovf_sticky, 1'b0);
    check("rst_count", ovf_count, 4'd0);
    rst = 1'b0;
    tick();

    // 1: unsigned wrap, 100*3 = 300 -> 44
    do_start(8'd3, 1'b0, 1'b0);
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_busy", busy, 1'b1);
    feed(8'd100, 0); feed(8'd100, 0); feed(8'd100, 0);
    check_result("t1", 8'd44, 1'b1, 4'd1);
    consume("t1");
    check("t1_keep_sum", out_sum, 8'd44);
    check("t1_keep_sticky", ovf_sticky, 1'b1);

    // 2: unsigned saturate -> 255
    do_start(8'd3, 1'b0, 1'b1);
    feed(8'd100, 0); feed(8'd100, 0); feed(8'd100, 0);
    check_result("t2", 8'd255, 1'b1, 4'd1);
    consume("t2");

    // 3: signed saturate, positive then negative
    do_start(8'd2, 1'b1, 1'b1);
    feed(8'h70, 0); feed(8'h20, 0);
    check_result("t3a", 8'h7F, 1'b1, 4'd1);
    consume("t3a");
    do_start(8'd2, 1'b1, 1'b1);
    feed(8'h90, 0); feed(8'hE0, 0);
    check_result("t3b", 8'h80, 1'b1, 4'd1);
    consume("t3b");

    // 4: signed wrap, with and without overflow
    do_start(8'd2, 1'b1, 1'b0);
    feed(8'h70, 0); feed(8'h20, 0);
    check_result("t4a", 8'h90, 1'b1, 4'd1);
    consume("t4a");
    do_start(8'd2, 1'b1, 1'b0);
    feed(8'h10, 0); feed(8'h20, 0);
    check_result("t4b", 8'h30, 1'b0, 4'd0);
    consume("t4b");

    // 5a: zero-length burst
    do_start(8'd0, 1'b0, 1'b0);
    check("t5a_in_ready", in_ready, 1'b0);
    check("t5a_busy", busy, 1'b1);
    check_result("t5a", 8'd0, 1'b0, 4'd0);
    consume("t5a");

    // 5b: 21 x 0xFF unsigned wrap: 20 overflows, counter saturates at 15; sum = -21 = 0xEB
    do_start(8'd21, 1'b0, 1'b0);
    for (int k = 0; k < 21; k++) feed(8'hFF, 0);
    check_result("t5b", 8'hEB, 1'b1, 4'd15);
    consume("t5b");

    // 6a: gaps, ignored start during ACC, output back-pressure
    do_start(8'd3, 1'b0, 1'b0);
    feed(8'd1, 2);
    start = 1'b1; len = 8'd5; sat_en = 1'b1;
    tick();
    start = 1'b0; len = 8'd0; sat_en = 1'b0;
    check("t6_busy_after_start", busy, 1'b1);
    check("t6_ready_after_start", in_ready, 1'b1);
    check("t6_partial_sum", out_sum, 8'd1);
    feed(8'd2, 1);
    check("t6_not_done", out_valid, 1'b0);
    feed(8'd3, 3);
    for (int k = 0; k < 5; k++) begin
      check("t6_hold_valid", out_valid, 1'b1);
      check("t6_hold_sum", out_sum, 8'd6);
      tick();
    end
    check_result("t6", 8'd6, 1'b0, 4'd0);
    consume("t6");

    // 6b: reset mid-burst aborts immediately
    do_start(8'd4, 1'b0, 1'b0);
    feed(8'hFF, 0); feed(8'hFF, 0);
    check("t6r_pre_sticky", ovf_sticky, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6r_in_ready", in_ready, 1'b0);
    check("t6r_out_valid", out_valid, 1'b0);
    check("t6r_busy", busy, 1'b0);
    check("t6r_sticky", ovf_sticky, 1'b0);
    check("t6r_count", ovf_count, 4'd0);
    check("t6r_sum", out_sum, 8'd0);
    rst = 1'b0;
    tick();
    tick();
    check("t6r_stay_idle", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
